hazard_ctrl: RTL and testbench

//  Pipeline hazard/sequencing controller for IF, IF/ID and ID/EX of the 5-stage RV64 core.

---
 rtl/hazard_ctrl_pkg.sv | 13 +
 rtl/hazard_ctrl_lu_detect.sv | 22 ++
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the IF/ID/EX hazard controller.
// FSM encodings and the canonical NOP used when flushing IF/ID.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IMEM_WAIT = 2'd1,
    FAULT     = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/hazard_ctrl_lu_detect.sv
// Load-use hazard compare between the EX load and the ID sources.
// Purely combinational; x0 never creates a dependency.
module lu_detect (
  input  logic [4:0] ID_rs1,
  input  logic [4:0] ID_rs2,
  input  logic       ID_uses_rs1,
  input  logic       ID_uses_rs2,
  input  logic       EX_mem_read,
  input  logic [4:0] EX_rd,
  output logic       lu_hazard
);

  logic hit1;
  logic hit2;

  assign hit1 = ID_uses_rs1 && (ID_rs1 == EX_rd);
  assign hit2 = ID_uses_rs2 && (ID_rs2 == EX_rd);

  assign lu_hazard = EX_mem_read && (EX_rd != 5'd0)
                  && (hit1 || hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: stalls, flushes, imem timeout
// fault and saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int IMEM_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic             EX_mem_read,
  input  logic [4:0]       EX_rd,
  input  logic             EX_branch_taken,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             fetch_fault,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(IMEM_TIMEOUT - 1);

  state_t          state;
  state_t          state_n;
  logic [WC_W-1:0] wait_cnt;
  logic [WC_W-1:0] wait_n;
  logic            lu_hazard;
  logic            in_fault;
  logic            do_br;
  logic            do_wait;
  logic            stall_inc;
  logic            flush_inc;

  lu_detect u_lu (
    .ID_rs1      (ID_rs1),
    .ID_rs2      (ID_rs2),
    .ID_uses_rs1 (ID_uses_rs1),
    .ID_uses_rs2 (ID_uses_rs2),
    .EX_mem_read (EX_mem_read),
    .EX_rd       (EX_rd),
    .lu_hazard   (lu_hazard)
  );

  // Mutually exclusive priority terms keep the decoder one-hot.
  assign in_fault = (state == FAULT);
  assign do_br    = !in_fault && EX_branch_taken;
  assign do_wait  = !in_fault && !EX_branch_taken && !imem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
    end
  end

  always_comb begin
    state_n      = state;
    wait_n       = wait_cnt;
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    flush_inc    = 1'b0;
    if (!reset) begin
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else begin
      unique case (1'b1)
        in_fault: begin
          pc_write     = 1'b0;
          IF_ID_write  = 1'b0;
          IF_ID_flush  = 1'b1;
          ID_EX_bubble = 1'b1;
        end
        do_br: begin
          IF_ID_flush  = 1'b1;
          ID_EX_bubble = 1'b1;
          state_n      = RUN;
          wait_n       = '0;
          flush_inc    = 1'b1;
        end
        do_wait: begin
          pc_write     = 1'b0;
          IF_ID_write  = !lu_hazard;
          IF_ID_flush  = 1'b1;
          ID_EX_bubble = lu_hazard;
          wait_n       = wait_cnt + 1'b1;
          if (state == IMEM_WAIT && wait_cnt == WC_LAST)
            state_n = FAULT;
          else
            state_n = IMEM_WAIT;
        end
        default: begin
          state_n = RUN;
          wait_n  = '0;
          if (lu_hazard) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
          end
        end
      endcase
    end
  end

  assign stall_inc   = reset && !in_fault && !pc_write;
  assign fetch_fault = in_fault;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_inc && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
      if (flush_inc && flush_count != '1)
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver queues expectations,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ID_rs1, ID_rs2, EX_rd;
  logic        ID_uses_rs1, ID_uses_rs2;
  logic        EX_mem_read, EX_branch_taken, imem_ready;

  logic        pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble;
  logic        fetch_fault;
  logic [31:0] stall_count, flush_count;

  logic        s_pw, s_iw, s_fl, s_bb, s_ft;
  logic [3:0]  s_stall, s_flush;

  typedef struct {
    string       nm;
    logic [4:0]  ctl;
    logic [31:0] st;
    logic [31:0] fc;
    logic [3:0]  sat;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned ts = 0;
  int unsigned tf = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.IMEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .EX_mem_read(EX_mem_read), .EX_rd(EX_rd),
    .EX_branch_taken(EX_branch_taken), .imem_ready(imem_ready),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_bubble(ID_EX_bubble),
    .fetch_fault(fetch_fault),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  hazard_ctrl #(.IMEM_TIMEOUT(16), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .EX_mem_read(EX_mem_read), .EX_rd(EX_rd),
    .EX_branch_taken(EX_branch_taken), .imem_ready(imem_ready),
    .pc_write(s_pw), .IF_ID_write(s_iw),
    .IF_ID_flush(s_fl), .ID_EX_bubble(s_bb),
    .fetch_fault(s_ft),
    .stall_count(s_stall), .flush_count(s_flush)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, ".ctl"},
          {27'd0, pc_write, IF_ID_write, IF_ID_flush,
           ID_EX_bubble, fetch_fault}, {27'd0, e.ctl});
      chk({e.nm, ".stall"}, stall_count, e.st);
      chk({e.nm, ".flush"}, flush_count, e.fc);
      chk({e.nm, ".sat"}, {28'd0, s_stall}, {28'd0, e.sat});
    end
  end

  task automatic drv(bit rst, logic [4:0] rs1, logic [4:0] rs2,
                     bit u1, bit u2, bit mr, logic [4:0] rd,
                     bit br, bit rdy);
    @(posedge clk);
    #1;
    reset           = rst;
    ID_rs1          = rs1;
    ID_rs2          = rs2;
    ID_uses_rs1     = u1;
    ID_uses_rs2     = u2;
    EX_mem_read     = mr;
    EX_rd           = rd;
    EX_branch_taken = br;
    imem_ready      = rdy;
  endtask

  // Expected counters are the tallies before this cycle's edge.
  task automatic exp(string nm, bit pw, bit iw, bit fl, bit bb, bit ft);
    exp_t e;
    if (!reset) begin
      ts = 0;
      tf = 0;
    end
    e.nm  = nm;
    e.ctl = {pw, iw, fl, bb, ft};
    e.st  = ts;
    e.fc  = tf;
    e.sat = (ts > 15) ? 4'hF : 4'(ts);
    q.push_back(e);
    if (reset && !ft && !pw) ts++;
    if (reset && pw && fl) tf++;
  endtask

  task automatic nrm(string nm);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1);
    exp(nm, 1, 1, 0, 0, 0);
  endtask

  task automatic rst_seq();
    for (int i = 0; i < 3; i++) begin
      drv(0, 5'($urandom), 5'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 5'($urandom),
          1'($urandom), 1'($urandom));
      exp("reset", 0, 0, 1, 1, 0);
    end
    nrm("rst_rel");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; ID_rs1 = 0; ID_rs2 = 0; EX_rd = 0;
    ID_uses_rs1 = 0; ID_uses_rs2 = 0; EX_mem_read = 0;
    EX_branch_taken = 0; imem_ready = 1;

    rst_seq();
    nrm("normal");

    drv(1, 0, 5, 0, 1, 1, 5, 0, 1);
    exp("lu_rs2", 0, 0, 0, 1, 0);
    nrm("lu_after");
    drv(1, 0, 0, 0, 1, 1, 0, 0, 1);
    exp("lu_x0", 1, 1, 0, 0, 0);
    drv(1, 7, 0, 1, 0, 1, 7, 0, 1);
    exp("lu_rs1", 0, 0, 0, 1, 0);
    drv(1, 7, 0, 0, 0, 1, 7, 0, 1);
    exp("lu_nouse", 1, 1, 0, 0, 0);

    drv(1, 0, 5, 0, 1, 1, 5, 1, 1);
    exp("br_lu", 1, 1, 1, 1, 0);
    nrm("br_after");

    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
      exp("imem_wait", 0, 1, 1, 0, 0);
    end
    nrm("imem_done");

    drv(1, 3, 0, 1, 0, 1, 3, 0, 0);
    exp("wait_lu", 0, 0, 1, 1, 0);
    nrm("wait_lu_done");

    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    exp("wait_br0", 0, 1, 1, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0);
    exp("wait_br", 1, 1, 1, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    exp("wait_br2", 0, 1, 1, 0, 0);
    nrm("wait_br_done");

    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    exp("mid_wait", 0, 1, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp("mid_rst", 0, 0, 1, 1, 0);
    nrm("mid_rel");

    for (int i = 0; i < 16; i++) begin
      drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
      exp("to_wait", 0, 1, 1, 0, 0);
    end
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    exp("fault", 0, 0, 1, 1, 1);
    for (int i = 0; i < 2; i++) begin
      drv(1, 0, 5, 0, 1, 1, 5, 1, 1);
      exp("fault_hold", 0, 0, 1, 1, 1);
    end
    rst_seq();

    for (int i = 0; i < 20; i++) begin
      drv(1, 0, 9, 0, 1, 1, 9, 0, 1);
      exp("sat_stall", 0, 0, 0, 1, 0);
    end
    nrm("sat_end");
    nrm("sat_hold");

    @(posedge clk);
    @(posedge clk);
    chk("q_drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
